// File: rtl/ysyx_25020032_axi_sram_slave_pkg.sv
// Shared definitions for the AXI SRAM responder: response codes, the accepted
// request format, FSM state encoding and the request classification helper.
package ysyx_25020032_axi_sram_slave_pkg;

  typedef enum logic [1:0] {
    RespOkay   = 2'b00,
    RespExOkay = 2'b01,
    RespSlvErr = 2'b10,
    RespDecErr = 2'b11
  } axi_resp_e;

  localparam logic [1:0] BurstIncr = 2'b01;
  localparam logic [2:0] SizeWord  = 3'b010;

  // The only request shape this responder serves: one beat, <= 4 bytes, INCR.
  localparam logic [3:0] DefaultId    = 4'h0;
  localparam logic [7:0] DefaultLen   = 8'h00;
  localparam logic [2:0] DefaultSize  = SizeWord;
  localparam logic [1:0] DefaultBurst = BurstIncr;

  typedef enum logic [2:0] {
    StIdle,
    StRWait,
    StRResp,
    StWCollect,
    StWWait,
    StBResp
  } state_e;

  // Classify a request. Address range is decided before request format, so an
  // out-of-range malformed request reports DECERR.
  function automatic axi_resp_e check_req(input logic [31:0] addr,
                                          input logic [31:0] base,
                                          input logic [32:0] span,
                                          input logic [7:0]  len,
                                          input logic [2:0]  size,
                                          input logic [1:0]  burst);
    logic [32:0] off;
    // Borrow into bit 32 flags addr < base.
    off = {1'b0, addr} - {1'b0, base};
    if (off[32] || (off >= span)) begin
      return RespDecErr;
    end else if ((len != DefaultLen) || (size > DefaultSize) || (burst != DefaultBurst)) begin
      return RespSlvErr;
    end
    return RespOkay;
  endfunction

endpackage

// File: rtl/ysyx_25020032_sram_bank.sv
// Word-organised SRAM: asynchronous read, synchronous write with per-byte enables.
// Contents are never reset.
module ysyx_25020032_sram_bank #(
  parameter int unsigned Words = 4096,
  parameter int unsigned IdxW  = $clog2(Words)
) (
  input  logic            clk_i,
  input  logic            we_i,
  input  logic [3:0]      be_i,
  input  logic [IdxW-1:0] addr_i,
  input  logic [31:0]     wdata_i,
  output logic [31:0]     rdata_o
);

  logic [31:0] mem_q [Words];

  // Byte-lane write; lanes with a clear enable keep their old value.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < 4; i++) begin
      if (we_i && be_i[i]) begin
        mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/ysyx_25020032_axi_sram_slave.sv
// AXI4 single-beat responder in front of a word SRAM, one transaction in flight.
// Optional feature: define AXI_SLAVE_RAND_DELAY_EN to add LFSR-driven extra
// latency and random ready deassertion in IDLE.
module ysyx_25020032_axi_sram_slave
  import ysyx_25020032_axi_sram_slave_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int unsigned RD_LAT    = 1,
  parameter int unsigned WR_LAT    = 1
) (
  input  logic        clk,
  input  logic        rst,
  // AR
  input  logic        arvalid,
  output logic        arready,
  input  logic [31:0] araddr,
  input  logic [3:0]  arid,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  // R
  output logic        rvalid,
  input  logic        rready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic [3:0]  rid,
  // AW
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] awaddr,
  input  logic [3:0]  awid,
  input  logic [7:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  // W
  input  logic        wvalid,
  output logic        wready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  // B
  output logic        bvalid,
  input  logic        bready,
  output logic [1:0]  bresp,
  output logic [3:0]  bid
);

  localparam int unsigned IdxW    = $clog2(MEM_WORDS);
  localparam logic [32:0] MemSpan = 33'(MEM_WORDS) << 2;
  localparam int unsigned CntW    = 8;

  state_e         state_q;
  logic [CntW-1:0] cnt_q;
  logic [31:0]    addr_q;
  logic [3:0]     id_q;
  axi_resp_e      resp_q;
  logic [31:0]    wdata_q;
  logic [3:0]     wstrb_q;

  logic           arready_q, awready_q, wready_q;
  logic           rvalid_q, rlast_q, bvalid_q;
  logic [31:0]    rdata_q;
  axi_resp_e      rresp_q, bresp_q;
  logic [3:0]     rid_q, bid_q;

  logic           ar_hs, aw_hs, w_hs;
  logic [CntW-1:0] extra;
  logic           idle_rdy;

  logic [31:0]    addr_off;
  logic [IdxW-1:0] mem_idx;
  logic           mem_we;
  logic [31:0]    mem_rdata;

  logic           unused_in;

`ifdef AXI_SLAVE_RAND_DELAY_EN
  logic [3:0] lfsr_q, lfsr_d;

  // x^4+x^3+1 Fibonacci LFSR, free-running.
  assign lfsr_d = {lfsr_q[2:0], lfsr_q[3] ^ lfsr_q[2]};

  // LFSR state, reseeded by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= 4'h9;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign extra    = CntW'(lfsr_q);
  // Readies are registered, so they follow the LFSR value of the coming cycle.
  assign idle_rdy = ~lfsr_d[0];
`else
  assign extra    = '0;
  assign idle_rdy = 1'b1;
`endif

  // A read accepted in IDLE blocks AW/W in the same cycle so only arready fires.
  assign ar_hs   = arvalid & arready_q;
  assign arready = arready_q;
  assign awready = awready_q & ~ar_hs;
  assign wready  = wready_q & ~ar_hs;
  assign aw_hs   = awvalid & awready;
  assign w_hs    = wvalid & wready;

  assign rvalid = rvalid_q;
  assign rdata  = rdata_q;
  assign rresp  = rresp_q;
  assign rlast  = rlast_q;
  assign rid    = rid_q;
  assign bvalid = bvalid_q;
  assign bresp  = bresp_q;
  assign bid    = bid_q;

  // Word index from the latched byte address; low two bits are ignored.
  assign addr_off = addr_q - BASE_ADDR;
  assign mem_idx  = addr_off[IdxW+1:2];
  assign mem_we   = (state_q == StWWait) && (cnt_q == '0) && (resp_q == RespOkay);

  assign unused_in = ^{wlast, addr_off[31:IdxW+2], addr_off[1:0]};

  ysyx_25020032_sram_bank #(
    .Words (MEM_WORDS),
    .IdxW  (IdxW)
  ) u_bank (
    .clk_i   (clk),
    .we_i    (mem_we),
    .be_i    (wstrb_q),
    .addr_i  (mem_idx),
    .wdata_i (wdata_q),
    .rdata_o (mem_rdata)
  );

  // Transaction FSM with all handshake/response outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      addr_q    <= '0;
      id_q      <= DefaultId;
      resp_q    <= RespOkay;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      arready_q <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RespOkay;
      rlast_q   <= 1'b1;
      rid_q     <= DefaultId;
      bvalid_q  <= 1'b0;
      bresp_q   <= RespOkay;
      bid_q     <= DefaultId;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (ar_hs) begin
            addr_q    <= araddr;
            id_q      <= arid;
            resp_q    <= check_req(araddr, BASE_ADDR, MemSpan, arlen, arsize, arburst);
            cnt_q     <= CntW'(RD_LAT - 1) + extra;
            state_q   <= StRWait;
            arready_q <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
          end else if (aw_hs || w_hs) begin
            if (aw_hs) begin
              addr_q <= awaddr;
              id_q   <= awid;
              resp_q <= check_req(awaddr, BASE_ADDR, MemSpan, awlen, awsize, awburst);
            end
            if (w_hs) begin
              wdata_q <= wdata;
              wstrb_q <= wstrb;
            end
            arready_q <= 1'b0;
            if (aw_hs && w_hs) begin
              cnt_q     <= CntW'(WR_LAT - 1) + extra;
              state_q   <= StWWait;
              awready_q <= 1'b0;
              wready_q  <= 1'b0;
            end else begin
              state_q   <= StWCollect;
              awready_q <= ~aw_hs;
              wready_q  <= ~w_hs;
            end
          end else begin
            arready_q <= idle_rdy;
            awready_q <= idle_rdy;
            wready_q  <= idle_rdy;
          end
        end
        StWCollect: begin
          if (aw_hs) begin
            addr_q <= awaddr;
            id_q   <= awid;
            resp_q <= check_req(awaddr, BASE_ADDR, MemSpan, awlen, awsize, awburst);
          end
          if (w_hs) begin
            wdata_q <= wdata;
            wstrb_q <= wstrb;
          end
          if (aw_hs || w_hs) begin
            cnt_q     <= CntW'(WR_LAT - 1) + extra;
            state_q   <= StWWait;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
          end
        end
        StRWait: begin
          if (cnt_q == '0) begin
            state_q  <= StRResp;
            rvalid_q <= 1'b1;
            rdata_q  <= (resp_q == RespOkay) ? mem_rdata : 32'h0;
            rresp_q  <= resp_q;
            rlast_q  <= 1'b1;
            rid_q    <= id_q;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        StRResp: begin
          if (rready) begin
            rvalid_q  <= 1'b0;
            state_q   <= StIdle;
            arready_q <= idle_rdy;
            awready_q <= idle_rdy;
            wready_q  <= idle_rdy;
          end
        end
        StWWait: begin
          // The SRAM write itself happens on this edge via mem_we.
          if (cnt_q == '0) begin
            state_q  <= StBResp;
            bvalid_q <= 1'b1;
            bresp_q  <= resp_q;
            bid_q    <= id_q;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        StBResp: begin
          if (bready) begin
            bvalid_q  <= 1'b0;
            state_q   <= StIdle;
            arready_q <= idle_rdy;
            awready_q <= idle_rdy;
            wready_q  <= idle_rdy;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule
